// File: rtl/vmem_pkg.sv
// Shared types and constants for the vmem responder.
// Macro VMEM_BURST_EN widens the legal burst length from 1 word to 1..MAX_BURST words.
package vmem_pkg;

  localparam int MAX_BURST = 5;
  localparam int LEN_W     = 3;
  localparam int WORD_W    = 32;
  localparam int CNT_W     = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_BEAT,
    ST_RESP
  } state_e;

  function automatic logic len_ok(input logic [LEN_W-1:0] len);
`ifdef VMEM_BURST_EN
    return (len != '0) && (len <= LEN_W'(MAX_BURST));
`else
    return len == LEN_W'(1);
`endif
  endfunction

endpackage

// File: rtl/vmem_resp_if.sv
// Request / write-data / read-data bundle between a requester (master) and vmem_resp (slave).
interface vmem_resp_if;
  import vmem_pkg::*;

  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [31:0]       req_addr;
  logic [LEN_W-1:0]  req_len;
  logic [WORD_W-1:0] wdata;
  logic              wdata_valid;
  logic              wdata_ready;
  logic [WORD_W-1:0] rdata;
  logic              rvalid;
  logic              done;
  logic              err;

  modport master (
    output req_valid, req_we, req_addr, req_len, wdata, wdata_valid,
    input  req_ready, wdata_ready, rdata, rvalid, done, err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_len, wdata, wdata_valid,
    output req_ready, wdata_ready, rdata, rvalid, done, err
  );

endinterface

// File: rtl/vmem_array.sv
// Word storage for vmem_resp: one asynchronous read port, one synchronous write port.
module vmem_array
  import vmem_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int AW    = 6
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [AW-1:0]     waddr_i,
  input  logic [WORD_W-1:0] wdata_i,
  input  logic [AW-1:0]     raddr_i,
  output logic [WORD_W-1:0] rdata_o
);

  logic [WORD_W-1:0] mem_q [DEPTH];

  // NOTE: the array has no reset branch -- contents must survive reset, and a
  // reset loop over every word would also stop it mapping onto RAM.
  // NOTE: sequential state is updated with <= so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/vmem_resp.sv
// Vector-memory burst responder: accepts one read/write burst, waits LATENCY cycles,
// streams the beats, then pulses done/err. Macro VMEM_BURST_EN enables multi-word bursts.
module vmem_resp
  import vmem_pkg::*;
#(
  parameter int DEPTH   = 64,
  parameter int LATENCY = 2
) (
  input logic        clk,
  input logic        reset,
  vmem_resp_if.slave bus
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  wait_q;
  logic [AW-1:0]     base_q;
  logic              we_q, we_d;
  logic              req_ready_q, rvalid_q, wdata_ready_q, done_q, err_q;

  logic              accept;
  logic              req_legal;
  logic              beat_fire;
  logic              last_beat;
  logic              mem_we;
  logic [31:0]       end_idx;
  logic [AW-1:0]     word_idx;
  logic [WORD_W-1:0] mem_rdata;

  assign accept    = bus.req_valid & req_ready_q;
  // Word index one past the burst; 32 bits cannot overflow from a 30-bit base plus len.
  assign end_idx   = {2'b00, bus.req_addr[31:2]} + 32'(bus.req_len);
  assign req_legal = (bus.req_addr[1:0] == 2'b00) && len_ok(bus.req_len) &&
                     (end_idx <= 32'(DEPTH));
  assign we_d      = accept ? bus.req_we : we_q;
  assign beat_fire = ~we_q | bus.wdata_valid;

`ifdef VMEM_BURST_EN
  logic [LEN_W-1:0] beat_q;
  logic [LEN_W-1:0] len_q;

  assign last_beat = (beat_q == len_q - LEN_W'(1));
  assign word_idx  = base_q + AW'(beat_q);
`else
  assign last_beat = 1'b1;
  assign word_idx  = base_q;
`endif

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (!req_legal)        state_d = ST_RESP;
          else if (LATENCY == 0) state_d = ST_BEAT;
          else                   state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (wait_q <= CNT_W'(1)) state_d = ST_BEAT;
      end
      ST_BEAT: begin
        if (beat_fire && last_beat) state_d = ST_RESP;
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      wait_q        <= '0;
      base_q        <= '0;
      we_q          <= 1'b0;
`ifdef VMEM_BURST_EN
      beat_q        <= '0;
      len_q         <= '0;
`endif
      req_ready_q   <= 1'b1;
      rvalid_q      <= 1'b0;
      wdata_ready_q <= 1'b0;
      done_q        <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        we_q   <= bus.req_we;
        base_q <= bus.req_addr[AW+1:2];
        wait_q <= CNT_W'(LATENCY);
`ifdef VMEM_BURST_EN
        len_q  <= bus.req_len;
        beat_q <= '0;
`endif
      end else if (state_q == ST_WAIT) begin
        wait_q <= wait_q - CNT_W'(1);
      end
`ifdef VMEM_BURST_EN
      else if (state_q == ST_BEAT && beat_fire) begin
        beat_q <= beat_q + LEN_W'(1);
      end
`endif
      // Outputs are decoded from the next state so they line up with state_q.
      req_ready_q   <= (state_d == ST_IDLE);
      rvalid_q      <= (state_d == ST_BEAT) & ~we_d;
      wdata_ready_q <= (state_d == ST_BEAT) & we_d;
      done_q        <= (state_d == ST_RESP);
      err_q         <= accept & ~req_legal;
    end
  end

  assign mem_we = wdata_ready_q & bus.wdata_valid & ~reset;

  vmem_array #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_array (
    .clk     (clk),
    .we_i    (mem_we),
    .waddr_i (word_idx),
    .wdata_i (bus.wdata),
    .raddr_i (word_idx),
    .rdata_o (mem_rdata)
  );

  assign bus.req_ready   = req_ready_q;
  assign bus.rvalid      = rvalid_q;
  assign bus.wdata_ready = wdata_ready_q;
  assign bus.done        = done_q;
  assign bus.err         = err_q;
  assign bus.rdata       = rvalid_q ? mem_rdata : '0;

endmodule
